// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and sizing helpers for the I2S/TDM transmitter
package i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int I2S_MODE_NUM_CH = 2;

    function automatic int frame_bits(input int num_ch, input int slot_w);
        return num_ch * slot_w;
    endfunction

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// rtl/i2s_sck_gen.sv - SCK divider with the strobe marking the cycle before each SCK fall
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int SCK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sck,
    output logic last_cycle
);

    localparam int D_W = cnt_w(SCK_DIV);
    localparam logic [D_W-1:0] D_LAST = D_W'(SCK_DIV - 1);
    localparam logic [D_W-1:0] D_HALF = D_W'(SCK_DIV / 2);

    logic [D_W-1:0] d;
    logic [D_W-1:0] d_next;

    always_comb begin
        d_next = '0;
        if (run && (d != D_LAST)) begin
            d_next = d + D_W'(1);
        end
    end

    // The edge ending this cycle takes d back to 0, i.e. SCK falls.
    assign last_cycle = run && (d == D_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d   <= '0;
            sck <= 1'b0;
        end else begin
            d   <= d_next;
            sck <= (d_next >= D_HALF);
        end
    end

endmodule

// File: rtl/i2s_tdm_tx.sv
// rtl/i2s_tdm_tx.sv - I2S/TDM serial audio transmitter; I2S_TX_UNDERRUN_CNT_EN adds an underrun counter
module i2s_tdm_tx
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW = 8,
    parameter int SLOT_W   = 16,
    parameter int NUM_CH   = 2,
    parameter int SCK_DIV  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic [NUM_CH*AUDIO_DW-1:0] sample_i,
    input  logic                       sample_valid_i,
    output logic                       sample_ready_o,
    output logic                       sck_o,
    output logic                       ws_o,
    output logic                       sd_o,
    output logic                       frame_start_o,
    output logic                       underrun_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]                 underrun_cnt_o
`endif
);

    localparam int FB  = frame_bits(NUM_CH, SLOT_W);
    localparam int B_W = cnt_w(FB);
    localparam logic [B_W-1:0] B_LAST = B_W'(FB - 1);

    state_t                     state;
    state_t                     state_next;
    logic                       entry;
    logic                       run;
    logic                       active;
    logic                       last_cycle;
    logic                       ld;
    logic                       hs;
    logic [B_W-1:0]             b;
    logic [B_W-1:0]             b_next;
    logic [B_W-1:0]             b_after;
    logic                       ws_next;
    logic                       hold_empty;
    logic [NUM_CH*AUDIO_DW-1:0] hold_data;
    logic [FB-1:0]              frame;
    logic [FB-1:0]              shreg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        entry      = 1'b0;
        run        = 1'b0;
        case (state)
            IDLE: begin
                entry = en_i;
                if (en_i) state_next = RUN;
            end
            RUN: begin
                run = en_i;
                if (!en_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign active = entry || run;

    i2s_sck_gen #(
        .SCK_DIV(SCK_DIV)
    ) u_sck (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .sck       (sck_o),
        .last_cycle(last_cycle)
    );

    assign ld = entry || (last_cycle && (b == B_LAST));
    assign hs = sample_valid_i && hold_empty;

    always_comb begin
        b_next = '0;
        if (run) begin
            b_next = b;
            if (last_cycle) b_next = (b == B_LAST) ? '0 : b + B_W'(1);
        end
        b_after = (b_next == B_LAST) ? '0 : b_next + B_W'(1);
    end

    // WS leads data by one bit: it reflects the slot of the bit that follows.
    always_comb begin
        ws_next = 1'b0;
        if (NUM_CH == I2S_MODE_NUM_CH) begin
            ws_next = active && (b_after >= B_W'(SLOT_W));
        end else begin
            ws_next = active && (b_next == B_LAST);
        end
    end

    always_comb begin
        frame = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            frame[FB-1-c*SLOT_W -: SLOT_W] =
                SLOT_W'(hold_data[c*AUDIO_DW +: AUDIO_DW]) << (SLOT_W - AUDIO_DW);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_empty    <= 1'b1;
            hold_data     <= '0;
            shreg         <= '0;
            b             <= '0;
            ws_o          <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
        end else begin
            b             <= b_next;
            ws_o          <= ws_next;
            frame_start_o <= ld;
            underrun_o    <= ld && hold_empty;
            if (!active) begin
                shreg <= '0;
            end else if (ld) begin
                shreg <= hold_empty ? '0 : frame;
            end else if (last_cycle) begin
                shreg <= shreg << 1;
            end
            // An empty-buffer load and a same-cycle handshake: the new frame waits for the next load.
            if (ld && !hold_empty) begin
                hold_empty <= 1'b1;
            end else if (hs) begin
                hold_empty <= 1'b0;
                hold_data  <= sample_i;
            end
        end
    end

    assign sd_o           = shreg[FB-1];
    assign sample_ready_o = hold_empty;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun_cnt_o <= '0;
        end else if (ld && hold_empty && (underrun_cnt_o != 8'hFF)) begin
            underrun_cnt_o <= underrun_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// tb/tb_i2s_tdm_tx.sv - scoreboard bench for i2s_tdm_tx in I2S (defaults) and TDM configurations
module tb_i2s_tdm_tx;

    typedef struct packed {
        logic [31:0] data;
        logic        ur;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    logic        en0, valid0, ready0, sck0, ws0, sd0, fs0, ur0;
    logic [15:0] sample0;
    logic        en1, valid1, ready1, sck1, ws1, sd1, fs1, ur1;
    logic [31:0] sample1;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [7:0]  cnt0, cnt1;
`endif

    logic [1:0]  m_fs, m_sd, m_ws, m_ur, m_en;
    assign m_fs = {fs1, fs0};
    assign m_sd = {sd1, sd0};
    assign m_ws = {ws1, ws0};
    assign m_ur = {ur1, ur0};
    assign m_en = {en1, en0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_tdm_tx u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en0),
        .sample_i      (sample0),
        .sample_valid_i(valid0),
        .sample_ready_o(ready0),
        .sck_o         (sck0),
        .ws_o          (ws0),
        .sd_o          (sd0),
        .frame_start_o (fs0),
        .underrun_o    (ur0)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o(cnt0)
`endif
    );

    i2s_tdm_tx #(
        .AUDIO_DW(8),
        .SLOT_W  (8),
        .NUM_CH  (4),
        .SCK_DIV (2)
    ) u_tdm (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en1),
        .sample_i      (sample1),
        .sample_valid_i(valid1),
        .sample_ready_o(ready1),
        .sck_o         (sck1),
        .ws_o          (ws1),
        .sd_o          (sd1),
        .frame_start_o (fs1),
        .underrun_o    (ur1)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o(cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic send0(input logic [15:0] d);
        int n = 0;
        sample0 = d;
        valid0  = 1'b1;
        while (!ready0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send0 timeout", 32'd0, 32'd1);
        @(negedge clk);
        valid0 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] d);
        int n = 0;
        sample1 = d;
        valid1  = 1'b1;
        while (!ready1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send1 timeout", 32'd0, 32'd1);
        @(negedge clk);
        valid1 = 1'b0;
    endtask

    // Captures one bit per SCK period after each frame_start; an en/reset drop truncates the frame.
    task automatic monitor(input int k, input int div, input logic [31:0] exp_ws);
        logic [31:0] cap, wcap, mask;
        int          nb, last_fs;
        bit          abort, prev_full, have;
        exp_t        e;
        last_fs   = 0;
        prev_full = 0;
        forever begin
            @(posedge clk);
            #2;
            if (m_fs[k] === 1'b1) begin
                if (prev_full) chk("frame period", cyc - last_fs, 32 * div);
                last_fs = cyc;
                have    = 0;
                e       = '0;
                if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
                if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
                if (!have) chk("unexpected frame", 32'd1, 32'd0);
                chk("underrun flag", {31'd0, m_ur[k]}, {31'd0, e.ur});
                cap   = '0;
                wcap  = '0;
                nb    = 0;
                abort = 0;
                for (int i = 0; i < 32 * div; i++) begin
                    if (i > 0) begin
                        @(posedge clk);
                        #2;
                    end
                    if (!m_en[k] || !rst_n) begin
                        abort = 1;
                        break;
                    end
                    if (i % div == 0) begin
                        cap[31-nb]  = m_sd[k];
                        wcap[31-nb] = m_ws[k];
                        nb++;
                    end
                end
                mask = ~(32'hFFFF_FFFF >> nb);
                if (abort) chk("partial frame", cap & mask, e.data & mask);
                else chk("frame data", cap, e.data);
                if (!abort) chk("ws pattern", wcap, exp_ws);
                prev_full = !abort;
            end
        end
    endtask

    initial monitor(0, 8, 32'h0001_FFFE);
    initial monitor(1, 2, 32'h0000_0001);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p2, p3, r0;
        rst_n   = 1'b0;
        en0     = 1'b0;
        en1     = 1'b0;
        valid0  = 1'b0;
        valid1  = 1'b0;
        sample0 = '0;
        sample1 = '0;
        repeat (3) @(negedge clk);
        chk("rst sck0", {31'd0, sck0}, 32'd0);
        chk("rst ws0", {31'd0, ws0}, 32'd0);
        chk("rst sd0", {31'd0, sd0}, 32'd0);
        chk("rst fs0", {31'd0, fs0}, 32'd0);
        chk("rst ur0", {31'd0, ur0}, 32'd0);
        chk("rst ready0", {31'd0, ready0}, 32'd1);
        chk("rst sck1", {31'd0, sck1}, 32'd0);
        chk("rst ws1", {31'd0, ws1}, 32'd0);
        chk("rst sd1", {31'd0, sd1}, 32'd0);
        chk("rst fs1", {31'd0, fs1}, 32'd0);
        chk("rst ur1", {31'd0, ur1}, 32'd0);
        chk("rst ready1", {31'd0, ready1}, 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("rst cnt1", {24'd0, cnt1}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        fork
            begin
                q0.push_back('{32'hA500_3C00, 1'b0});
                send0(16'h3CA5);
                chk("ready0 after accept", {31'd0, ready0}, 32'd0);
                en0 = 1'b1;
                p0  = cyc;
                wait_neg(p0 + 1);
                chk("first fs", {31'd0, fs0}, 32'd1);
                chk("first sd msb", {31'd0, sd0}, 32'd1);
                chk("first ready", {31'd0, ready0}, 32'd1);
                q0.push_back('{32'h8100_7E00, 1'b0});
                send0(16'h7E81);
                q0.push_back('{32'h0, 1'b1});
                q0.push_back('{32'h0, 1'b1});
                q0.push_back('{32'hC300_1800, 1'b0});
                wait_neg(p0 + 768);
                sample0 = 16'h18C3;
                valid0  = 1'b1;
                @(negedge clk);
                valid0 = 1'b0;
                chk("same-cycle underrun", {31'd0, ur0}, 32'd1);
                chk("same-cycle fs", {31'd0, fs0}, 32'd1);
                chk("same-cycle ready", {31'd0, ready0}, 32'd0);
                wait_neg(p0 + 1025);
                q0.push_back('{32'hF000_0F00, 1'b0});
                send0(16'h0FF0);
                wait_neg(p0 + 1025 + 61);
                chk("pre-drop sck", {31'd0, sck0}, 32'd1);
                chk("pre-drop sd", {31'd0, sd0}, 32'd1);
                en0 = 1'b0;
                @(negedge clk);
                chk("drop sck", {31'd0, sck0}, 32'd0);
                chk("drop ws", {31'd0, ws0}, 32'd0);
                chk("drop sd", {31'd0, sd0}, 32'd0);
                chk("drop retained", {31'd0, ready0}, 32'd0);
                repeat (5) @(negedge clk);
                q0.push_back('{32'h0, 1'b1});
                en0 = 1'b1;
                p2  = cyc;
                wait_neg(p2 + 1);
                chk("restart fs", {31'd0, fs0}, 32'd1);
                chk("restart ur", {31'd0, ur0}, 32'd0);
                chk("restart sd", {31'd0, sd0}, 32'd1);
                wait_neg(p2 + 1 + 256 + 40);
                en0 = 1'b0;
            end
            begin
                q1.push_back('{32'h0102_0304, 1'b0});
                send1(32'h0403_0201);
                for (int n = 1; n <= 301; n++) q1.push_back('{32'h0, 1'b1});
                en1 = 1'b1;
                r0  = cyc;
                wait_neg(r0 + 1 + 64 * 3);
                chk("tdm underrun", {31'd0, ur1}, 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
                chk("cnt after 3", {24'd0, cnt1}, 32'd3);
`endif
                wait_neg(r0 + 1 + 64 * 301 + 10);
`ifdef I2S_TX_UNDERRUN_CNT_EN
                chk("cnt saturated", {24'd0, cnt1}, 32'd255);
`endif
                en1 = 1'b0;
            end
        join

        repeat (4) @(negedge clk);
        q0.push_back('{32'h1100_2200, 1'b0});
        send0(16'h2211);
        en0 = 1'b1;
        p3  = cyc;
        wait_neg(p3 + 5);
        send0(16'h4433);
        wait_neg(p3 + 50);
        chk("ready before reset", {31'd0, ready0}, 32'd0);
        rst_n = 1'b0;
        en0   = 1'b0;
        @(negedge clk);
        chk("mid rst sck", {31'd0, sck0}, 32'd0);
        chk("mid rst ws", {31'd0, ws0}, 32'd0);
        chk("mid rst sd", {31'd0, sd0}, 32'd0);
        chk("mid rst fs", {31'd0, fs0}, 32'd0);
        chk("mid rst ur", {31'd0, ur0}, 32'd0);
        chk("mid rst ready", {31'd0, ready0}, 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("mid rst cnt1", {24'd0, cnt1}, 32'd0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("q0 drained", q0.size(), 32'd0);
        chk("q1 drained", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
